// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: 16/32-bit instruction assembly, FIFO to decode, branch redirect
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 6,
    parameter int WORD_WIDTH  = 16,
    parameter int QUEUE_DEPTH = 2,
    parameter int RESET_PC    = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic [ADDR_WIDTH-1:0]   fetch_rd1_addr,
    output logic [ADDR_WIDTH-1:0]   fetch_rd2_addr,
    input  logic [WORD_WIDTH-1:0]   fetch_rd1_data,
    input  logic [WORD_WIDTH-1:0]   fetch_rd2_data,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    decode_valid,
    input  logic                    decode_ready,
    output logic [2*WORD_WIDTH-1:0] decode_instr,
    output logic                    decode_long,
    output logic [ADDR_WIDTH-1:0]   decode_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [CW-1:0]           count_q, count_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;

    logic [2*WORD_WIDTH-1:0] instr_q [QUEUE_DEPTH];
    logic                    long_q  [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]   epc_q   [QUEUE_DEPTH];

    logic                    fetch_long;
    logic [2*WORD_WIDTH-1:0] fetch_instr;
    logic                    pop;
    logic                    push;

    // Memory addresses and assembly of the instruction sitting at pc
    always_comb begin
        fetch_rd1_addr = pc_q;
        fetch_rd2_addr = pc_q + ADDR_WIDTH'(1);
        fetch_long     = fetch_rd1_data[WORD_WIDTH-1];
        fetch_instr    = fetch_long ? {fetch_rd2_data, fetch_rd1_data}
                                    : {{WORD_WIDTH{1'b0}}, fetch_rd1_data};
        pop            = decode_valid & decode_ready;
        // A full queue can still accept when the head leaves in the same cycle
        push           = ~redirect_valid & ((count_q < CW'(QUEUE_DEPTH)) | pop);
    end

    // Next-state for pc, occupancy and pointers; redirect flushes everything
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + (fetch_long ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state registers; reset dominates redirect, push and pop
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= ADDR_WIDTH'(RESET_PC);
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            instr_q[wr_ptr_q] <= fetch_instr;
            long_q[wr_ptr_q]  <= fetch_long;
            epc_q[wr_ptr_q]   <= pc_q;
        end
    end

    // Head presentation, zeroed while the queue is empty
    always_comb begin
        decode_valid = (count_q != '0);
        queue_count  = count_q;
        decode_instr = '0;
        decode_long  = 1'b0;
        decode_pc    = '0;
        if (decode_valid) begin
            decode_instr = instr_q[rd_ptr_q];
            decode_long  = long_q[rd_ptr_q];
            decode_pc    = epc_q[rd_ptr_q];
        end
    end

endmodule
